ready_bit_ram_cfg: RTL and testbench

Parametrised, partition-gated multi-port ready-bit RAM for the active list. It supersedes the fixed-width commit-ready RAM.
- Any number of write ports (issue plus commit lanes) and read ports (commit lanes), set by parameters.
- Per-port and per-partition power gating for dynamic configuration.
- A sequential clear state machine. It runs at reset, on flush and on partition re-activation, and reports ramReady_o when complete.
- Sits beside the active list, with writes from writeback/commit and reads from retire.

---
 rtl/ready_ram_pkg.sv | 15 +
 rtl/ready_ram_clear_fsm.sv | 65 ++++++
 rtl/ready_bit_ram_cfg.sv | 102 ++++++++++
 tb/tb_ready_bit_ram_cfg.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ready_ram_pkg.sv
// Shared types and helpers for the partition-gated ready-bit RAM.
package ready_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ready_ram_state_t;

    localparam int RAM_PART_LOG = 2;

    function automatic int ram_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ready_ram_clear_fsm.sv
// Sequential row-clear controller: runs after reset, flush and
// partition re-activation, and tells the RAM when it is usable.
module ready_ram_clear_fsm
    import ready_ram_pkg::*;
#(
    parameter int NUM_PARTS = 4,
    parameter int ROWS      = 4,
    parameter int ROW_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic [NUM_PARTS-1:0] partGated_i,
    output logic                 clrEn,
    output logic [ROW_W-1:0]     clrRow,
    output logic                 ramReady_o
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    ready_ram_state_t     state;
    logic [NUM_PARTS-1:0] partGatedQ;
    logic                 trig;

    // A partition powering back up holds garbage, so it forces a clear.
    assign trig  = flush_i | (|(partGatedQ & ~partGated_i));
    assign clrEn = (state == CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            clrRow     <= '0;
            ramReady_o <= 1'b0;
            partGatedQ <= '0;
        end else begin
            partGatedQ <= partGated_i;
            unique case (state)
                CLEAR: begin
                    if (trig) begin
                        clrRow <= '0;
                    end else if (clrRow == LAST_ROW) begin
                        state      <= READY;
                        ramReady_o <= 1'b1;
                        clrRow     <= '0;
                    end else begin
                        clrRow <= clrRow + 1'b1;
                    end
                end
                READY: begin
                    if (trig) begin
                        state      <= CLEAR;
                        ramReady_o <= 1'b0;
                        clrRow     <= '0;
                    end
                end
                default: begin
                    state      <= CLEAR;
                    ramReady_o <= 1'b0;
                    clrRow     <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ready_bit_ram_cfg.sv
// Multi-port ready-bit RAM for the active list with per-port and
// per-partition gating; storage is zeroed row by row by the clear FSM.
module ready_bit_ram_cfg
    import ready_ram_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int INDEX     = 4,
    parameter int WIDTH     = 8,
    parameter int NUM_WR    = 6,
    parameter int NUM_RD    = 4,
    parameter int NUM_PARTS = 1 << RAM_PART_LOG,
    parameter int BYPASS    = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush_i,
    input  logic [NUM_WR-1:0]               wrPortGated_i,
    input  logic [NUM_RD-1:0]               rdPortGated_i,
    input  logic [NUM_PARTS-1:0]            partGated_i,
    input  logic [NUM_RD-1:0][INDEX-1:0]    addr_i,
    output logic [NUM_RD-1:0][WIDTH-1:0]    data_o,
    input  logic [NUM_WR-1:0][INDEX-1:0]    addrWr_i,
    input  logic [NUM_WR-1:0][WIDTH-1:0]    dataWr_i,
    input  logic [NUM_WR-1:0]               wrEn_i,
    output logic                            ramReady_o
);

    localparam int ROWS  = DEPTH / NUM_PARTS;
    localparam int PLOG  = $clog2(NUM_PARTS);
    localparam int RBITS = INDEX - PLOG;
    localparam int ROW_W = ram_bits(ROWS);
    localparam int PW    = ram_bits(NUM_PARTS);

    function automatic logic [PW-1:0] part_of(input logic [INDEX-1:0] a);
        logic [INDEX-1:0] s;
        s = a >> RBITS;
        return s[PW-1:0];
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic             clrEn;
    logic [ROW_W-1:0] clrRow;
    logic [NUM_WR-1:0] wrOk;

    ready_ram_clear_fsm #(
        .NUM_PARTS (NUM_PARTS),
        .ROWS      (ROWS),
        .ROW_W     (ROW_W)
    ) u_clear_fsm (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .partGated_i (partGated_i),
        .clrEn       (clrEn),
        .clrRow      (clrRow),
        .ramReady_o  (ramReady_o)
    );

    always_comb begin
        wrOk = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wrOk[w] = wrEn_i[w] & ~wrPortGated_i[w] & ramReady_o
                    & ~partGated_i[part_of(addrWr_i[w])];
        end
    end

    // Ascending port order lets commit lanes override issue lanes.
    always_ff @(posedge clk) begin
        if (clrEn) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                if (!partGated_i[p]) begin
                    mem[INDEX'(p * ROWS) | INDEX'(clrRow)] <= '0;
                end
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wrOk[w]) begin
                    mem[addrWr_i[w]] <= dataWr_i[w];
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            data_o[r] = mem[addr_i[r]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wrOk[w] && (addrWr_i[w] == addr_i[r])) begin
                        data_o[r] = dataWr_i[w];
                    end
                end
            end
            if (rdPortGated_i[r] || !ramReady_o
                || partGated_i[part_of(addr_i[r])]) begin
                data_o[r] = '0;
            end
        end
    end

endmodule

// File: tb/tb_ready_bit_ram_cfg.sv
// Randomised scoreboard bench for ready_bit_ram_cfg, checking a
// non-bypass and a bypass instance against one behavioural model.
module tb_ready_bit_ram_cfg;

    localparam int DEPTH     = 16;
    localparam int INDEX     = 4;
    localparam int WIDTH     = 8;
    localparam int NUM_WR    = 6;
    localparam int NUM_RD    = 4;
    localparam int NUM_PARTS = 4;
    localparam int ROWS      = DEPTH / NUM_PARTS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic [NUM_WR-1:0]            wr_g = '0;
    logic [NUM_WR-1:0]            wr_en = '0;
    logic [NUM_RD-1:0]            rd_g = '0;
    logic [NUM_PARTS-1:0]         part_g = '0;
    logic [NUM_RD-1:0][INDEX-1:0] addr = '0;
    logic [NUM_WR-1:0][INDEX-1:0] waddr = '0;
    logic [NUM_WR-1:0][WIDTH-1:0] wdata = '0;
    logic [NUM_RD-1:0][WIDTH-1:0] data0, data1;
    logic rdy0, rdy1;

    always #5 clk = ~clk;

    ready_bit_ram_cfg #(.BYPASS(0)) u_dut (
        .clk(clk), .reset(reset), .flush_i(flush),
        .wrPortGated_i(wr_g), .rdPortGated_i(rd_g),
        .partGated_i(part_g), .addr_i(addr), .data_o(data0),
        .addrWr_i(waddr), .dataWr_i(wdata), .wrEn_i(wr_en),
        .ramReady_o(rdy0)
    );

    ready_bit_ram_cfg #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .flush_i(flush),
        .wrPortGated_i(wr_g), .rdPortGated_i(rd_g),
        .partGated_i(part_g), .addr_i(addr), .data_o(data1),
        .addrWr_i(waddr), .dataWr_i(wdata), .wrEn_i(wr_en),
        .ramReady_o(rdy1)
    );

    typedef struct {
        bit                           rdy;
        logic [NUM_RD-1:0][WIDTH-1:0] d0;
        logic [NUM_RD-1:0][WIDTH-1:0] d1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    int             mem_m[DEPTH];
    int             left;
    bit             m_ready;
    logic [NUM_PARTS-1:0] prev_g;

    function automatic int part(input int a);
        return a / ROWS;
    endfunction

    function automatic bit wr_q(input int w);
        return m_ready && wr_en[w] && !wr_g[w] && !part_g[part(int'(waddr[w]))];
    endfunction

    task automatic push_exp();
        exp_t e;
        int base, byp;
        e.rdy = m_ready;
        for (int r = 0; r < NUM_RD; r++) begin
            base = mem_m[addr[r]];
            byp  = base;
            for (int w = 0; w < NUM_WR; w++)
                if (wr_q(w) && waddr[w] == addr[r]) byp = int'(wdata[w]);
            if (!m_ready || rd_g[r] || part_g[part(int'(addr[r]))]) begin
                base = 0;
                byp  = 0;
            end
            e.d0[r] = WIDTH'(base);
            e.d1[r] = WIDTH'(byp);
        end
        sb.push_back(e);
    endtask

    task automatic model_edge();
        bit trig;
        trig = flush || ((prev_g & ~part_g) != '0);
        if (m_ready) begin
            for (int w = 0; w < NUM_WR; w++)
                if (wr_q(w)) mem_m[waddr[w]] = int'(wdata[w]);
            if (trig) begin
                m_ready = 0;
                left = ROWS;
            end
        end else if (trig) begin
            left = ROWS;
        end else begin
            left--;
            if (left == 0) begin
                m_ready = 1;
                for (int a = 0; a < DEPTH; a++)
                    if (!part_g[part(a)]) mem_m[a] = 0;
            end
        end
        prev_g = part_g;
    endtask

    task automatic model_reset();
        left = ROWS;
        m_ready = 0;
        prev_g = '0;
    endtask

    task automatic step();
        push_exp();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        wr_en = '0;
        wr_g = '0;
        rd_g = '0;
    endtask

    task automatic rand_rw();
        for (int r = 0; r < NUM_RD; r++) addr[r] = INDEX'($urandom);
        for (int w = 0; w < NUM_WR; w++) begin
            waddr[w] = INDEX'($urandom_range(0, 7) * 2);
            wdata[w] = WIDTH'($urandom);
        end
        wr_en = NUM_WR'($urandom);
    endtask

    task automatic full_read();
        idle();
        for (int i = 0; i < ROWS; i++) begin
            for (int r = 0; r < NUM_RD; r++) addr[r] = INDEX'(r * ROWS + i);
            step();
        end
    endtask

    task automatic chk_bit(input string n, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk_bit("ready_nobyp", rdy0, mon_e.rdy);
            chk_bit("ready_byp", rdy1, mon_e.rdy);
            for (int r = 0; r < NUM_RD; r++) begin
                checks += 2;
                if (data0[r] !== mon_e.d0[r]) begin
                    failures++;
                    $display("FAIL data%0d_nobyp addr=%0d got=%h exp=%h",
                             r, addr[r], data0[r], mon_e.d0[r]);
                end
                if (data1[r] !== mon_e.d1[r]) begin
                    failures++;
                    $display("FAIL data%0d_byp addr=%0d got=%h exp=%h",
                             r, addr[r], data1[r], mon_e.d1[r]);
                end
            end
        end
    end

    initial begin
        model_reset();
        for (int a = 0; a < DEPTH; a++) mem_m[a] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // initial clear, then every entry reads zero
        for (int i = 0; i < ROWS + 2; i++) begin
            for (int r = 0; r < NUM_RD; r++) addr[r] = INDEX'($urandom);
            step();
        end
        full_read();

        // same-address collision: port 5 beats port 0
        wr_en = 6'b100001;
        waddr[0] = 4'd3; wdata[0] = 8'h5A;
        waddr[5] = 4'd3; wdata[5] = 8'hA5;
        addr[0] = 4'd3;
        step();
        idle();
        step();

        // gated partition 1 drops writes and reads zero
        part_g = 4'b0010;
        step();
        wr_en = 6'b000110;
        waddr[1] = 4'd5; wdata[1] = 8'h11;
        waddr[2] = 4'd9; wdata[2] = 8'h11;
        step();
        idle();
        addr[0] = 4'd5;
        addr[1] = 4'd9;
        step();

        // re-activation clears; writes during clear are lost
        part_g = 4'b0000;
        step();
        for (int i = 0; i < ROWS; i++) begin
            wr_en = 6'b001000;
            waddr[3] = 4'd9;
            wdata[3] = 8'h77;
            step();
        end
        idle();
        step();
        step();

        // flush, then flush again in the 2nd clear cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (ROWS + 2) step();

        // randomised traffic with occasional gating and flushes
        repeat (400) begin
            rand_rw();
            wr_g = ($urandom_range(0, 7) == 0) ? NUM_WR'($urandom) : '0;
            rd_g = ($urandom_range(0, 7) == 0) ? NUM_RD'($urandom) : '0;
            flush = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 24) == 0) part_g = NUM_PARTS'($urandom);
            step();
        end

        // asynchronous reset in the middle of a write burst
        idle();
        part_g = '0;
        for (int i = 0; i < 3 * ROWS && !m_ready; i++) step();
        chk_bit("ready_before_burst", rdy0, 1'b1);
        repeat (3) begin
            rand_rw();
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        chk_bit("async_reset_nobyp", rdy0, 1'b0);
        chk_bit("async_reset_byp", rdy1, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
            rand_rw();
            step();
        end
        full_read();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
